// File: rtl/pim_dma_ctrl_if.sv
// pim_dma_ctrl_if: command, dmem-bus and PIM stream signals of the DMA engine.
// master = DMA engine side; slave = core / dmem arbiter / PIM environment side.
interface pim_dma_ctrl_if #(
  parameter int unsigned XLEN = 32
);
  logic            dma_en_i;
  logic [2:0]      dma_funct3_i;
  logic [3:0]      dma_sel_pim_i;
  logic [12:0]     dma_size_i;
  logic [XLEN-1:0] dma_mem_addr_i;
  logic            dma_busy_o;

  logic            mem_req_o;
  logic            mem_gnt_i;
  logic [XLEN-1:0] mem_addr_o;
  logic [XLEN-1:0] mem_wr_data_o;
  logic [XLEN-1:0] mem_rd_data_i;
  logic [3:0]      mem_size_o;
  logic            mem_read_o;
  logic            mem_write_o;

  logic [3:0]      pim_sel_o;
  logic [10:0]     pim_idx_o;
  logic            pim_wr_valid_o;
  logic            pim_wr_ready_i;
  logic [XLEN-1:0] pim_wr_data_o;
  logic            pim_rd_valid_i;
  logic            pim_rd_ready_o;
  logic [XLEN-1:0] pim_rd_data_i;

  logic            err_o;

  modport master (
    input  dma_en_i, dma_funct3_i, dma_sel_pim_i, dma_size_i, dma_mem_addr_i,
           mem_gnt_i, mem_rd_data_i, pim_wr_ready_i, pim_rd_valid_i, pim_rd_data_i,
    output dma_busy_o, mem_req_o, mem_addr_o, mem_wr_data_o, mem_size_o, mem_read_o,
           mem_write_o, pim_sel_o, pim_idx_o, pim_wr_valid_o, pim_wr_data_o,
           pim_rd_ready_o, err_o
  );

  modport slave (
    output dma_en_i, dma_funct3_i, dma_sel_pim_i, dma_size_i, dma_mem_addr_i,
           mem_gnt_i, mem_rd_data_i, pim_wr_ready_i, pim_rd_valid_i, pim_rd_data_i,
    input  dma_busy_o, mem_req_o, mem_addr_o, mem_wr_data_o, mem_size_o, mem_read_o,
           mem_write_o, pim_sel_o, pim_idx_o, pim_wr_valid_o, pim_wr_data_o,
           pim_rd_ready_o, err_o
  );
endinterface

// File: rtl/pim_dma_ctrl.sv
// pim_dma_ctrl: word-granular DMA between dmem and one of four PIM units, FIFO-decoupled.
// Define PIM_DMA_ALIGN_CHK_EN to reject misaligned/illegal commands and flag them on err_o.
module pim_dma_ctrl #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  pim_dma_ctrl_if.master bus_io
);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StLoad, StStore, StDone} state_e;

  state_e          r_state;
  logic            r_busy;
  logic [3:0]      r_sel;
  logic [XLEN-1:0] r_addr;
  logic [10:0]     r_n;
  logic [10:0]     r_mem_cnt;
  logic [10:0]     r_pim_idx;
  logic            r_rd_pend;
  logic [XLEN-1:0] r_fifo [FIFO_DEPTH];
  logic [PtrW-1:0] r_wptr;
  logic [PtrW-1:0] r_rptr;
  logic [CntW-1:0] r_count;
`ifdef PIM_DMA_ALIGN_CHK_EN
  logic            r_err;
`endif

  logic            w_empty, w_full;
  logic [CntW:0]   w_inflight;
  logic            w_rd_req, w_wr_req, w_req, w_rd_gnt, w_wr_gnt;
  logic            w_pim_wr_valid, w_pim_wr_hs, w_pim_rd_ready, w_pim_rd_hs;
  logic            w_push, w_pop;
  logic [XLEN-1:0] w_head, w_push_data;
  logic [10:0]     w_n;
  logic            w_f3_ok, w_cmd_bad;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CntW'(FIFO_DEPTH));
  assign w_head     = r_fifo[r_rptr];
  // A granted read occupies a FIFO slot until its data lands the next cycle.
  assign w_inflight = {1'b0, r_count} + {{CntW{1'b0}}, r_rd_pend};

  assign w_rd_req = (r_state == StLoad) && (r_mem_cnt < r_n) &&
                    (w_inflight < (CntW + 1)'(FIFO_DEPTH));
  assign w_wr_req = (r_state == StStore) && !w_empty;
  assign w_req    = w_rd_req || w_wr_req;
  assign w_rd_gnt = w_rd_req && bus_io.mem_gnt_i;
  assign w_wr_gnt = w_wr_req && bus_io.mem_gnt_i;

  assign w_pim_wr_valid = (r_state == StLoad) && !w_empty;
  assign w_pim_wr_hs    = w_pim_wr_valid && bus_io.pim_wr_ready_i;
  assign w_pim_rd_ready = (r_state == StStore) && (r_pim_idx < r_n) && !w_full;
  assign w_pim_rd_hs    = w_pim_rd_ready && bus_io.pim_rd_valid_i;

  assign w_push      = r_rd_pend || w_pim_rd_hs;
  assign w_pop       = w_pim_wr_hs || w_wr_gnt;
  assign w_push_data = (r_state == StLoad) ? bus_io.mem_rd_data_i : bus_io.pim_rd_data_i;

  assign w_n     = bus_io.dma_size_i[12:2];
  assign w_f3_ok = (bus_io.dma_funct3_i == 3'b000) || (bus_io.dma_funct3_i == 3'b001);

`ifdef PIM_DMA_ALIGN_CHK_EN
  assign w_cmd_bad = !w_f3_ok ||
                     (bus_io.dma_size_i[1:0] != 2'b00) ||
                     (bus_io.dma_mem_addr_i[1:0] != 2'b00) ||
                     (bus_io.dma_sel_pim_i == 4'd0) ||
                     ((bus_io.dma_sel_pim_i & (bus_io.dma_sel_pim_i - 4'd1)) != 4'd0);
`else
  logic w_unused_align;
  assign w_unused_align = ^{bus_io.dma_size_i[1:0], bus_io.dma_mem_addr_i[1:0]};
  assign w_cmd_bad      = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= StIdle;
      r_busy    <= 1'b0;
      r_sel     <= '0;
      r_addr    <= '0;
      r_n       <= '0;
      r_mem_cnt <= '0;
      r_pim_idx <= '0;
      r_rd_pend <= 1'b0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
`ifdef PIM_DMA_ALIGN_CHK_EN
      r_err     <= 1'b0;
`endif
    end else begin
      r_rd_pend <= w_rd_gnt;
      if (w_push) begin
        r_fifo[r_wptr] <= w_push_data;
        r_wptr         <= r_wptr + PtrW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PtrW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CntW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CntW'(1);
      if (w_rd_gnt || w_wr_gnt) begin
        r_addr    <= r_addr + XLEN'(4);
        r_mem_cnt <= r_mem_cnt + 11'd1;
      end
      if (w_pim_wr_hs || w_pim_rd_hs) r_pim_idx <= r_pim_idx + 11'd1;

      unique case (r_state)
        StIdle: begin
          if (bus_io.dma_en_i) begin
            if (w_cmd_bad) begin
`ifdef PIM_DMA_ALIGN_CHK_EN
              r_err <= 1'b1;
`endif
            end else if ((w_n == 11'd0) || w_f3_ok) begin
              r_sel     <= bus_io.dma_sel_pim_i;
              r_addr    <= {bus_io.dma_mem_addr_i[XLEN-1:2], 2'b00};
              r_n       <= w_n;
              r_mem_cnt <= '0;
              r_pim_idx <= '0;
              r_busy    <= 1'b1;
`ifdef PIM_DMA_ALIGN_CHK_EN
              r_err     <= 1'b0;
`endif
              if (w_n == 11'd0)                       r_state <= StDone;
              else if (bus_io.dma_funct3_i == 3'b000) r_state <= StLoad;
              else                                    r_state <= StStore;
            end
          end
        end
        StLoad: begin
          if (w_pim_wr_hs && (r_pim_idx + 11'd1 == r_n)) r_state <= StDone;
        end
        StStore: begin
          if (w_wr_gnt && (r_mem_cnt + 11'd1 == r_n)) r_state <= StDone;
        end
        StDone: begin
          r_state   <= StIdle;
          r_busy    <= 1'b0;
          r_mem_cnt <= '0;
          r_pim_idx <= '0;
          r_rd_pend <= 1'b0;
          r_wptr    <= '0;
          r_rptr    <= '0;
          r_count   <= '0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus_io.dma_busy_o     = r_busy;
  assign bus_io.mem_req_o      = w_req;
  assign bus_io.mem_addr_o     = r_addr;
  assign bus_io.mem_wr_data_o  = w_wr_req ? w_head : '0;
  assign bus_io.mem_size_o     = w_req ? 4'b1111 : 4'b0000;
  assign bus_io.mem_read_o     = w_rd_req;
  assign bus_io.mem_write_o    = w_wr_req;
  assign bus_io.pim_sel_o      = r_sel;
  assign bus_io.pim_idx_o      = r_pim_idx;
  assign bus_io.pim_wr_valid_o = w_pim_wr_valid;
  assign bus_io.pim_wr_data_o  = w_pim_wr_valid ? w_head : '0;
  assign bus_io.pim_rd_ready_o = w_pim_rd_ready;
`ifdef PIM_DMA_ALIGN_CHK_EN
  assign bus_io.err_o          = r_err;
`else
  assign bus_io.err_o          = 1'b0;
`endif
endmodule

// File: tb/tb_pim_dma_ctrl.sv
// tb_pim_dma_ctrl: directed bench for pim_dma_ctrl with dmem/PIM responders.
// Honours PIM_DMA_ALIGN_CHK_EN for the alignment scenario.
module tb_pim_dma_ctrl;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned DEPTH  = 4;
  localparam logic [31:0] ST_PAT = 32'hC0DE_0000;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  pim_dma_ctrl_if #(.XLEN(XLEN)) bus ();

  pim_dma_ctrl #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .bus_io (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Responder / monitor state.
  int          cyc = 0;
  int          stall_until = 0;
  bit          gnt_toggle = 1'b0;
  logic [31:0] rd_addr_q[$];
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] pimw_data_q[$];
  int          pimw_idx_q[$];
  int          req_cnt = 0, stall_reads = 0;
  int          st_occ = 0, st_rd_cnt = 0, ready_full = 0, full_blocked = 0;
  bit          rd_pend = 1'b0;
  logic [31:0] rd_pend_addr = '0;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [63:0] outs_or();
    return 64'({bus.mem_addr_o | bus.mem_wr_data_o | bus.pim_wr_data_o,
                bus.dma_busy_o, bus.mem_req_o, bus.mem_read_o, bus.mem_write_o,
                bus.mem_size_o, bus.pim_sel_o, bus.pim_idx_o, bus.pim_wr_valid_o,
                bus.pim_rd_ready_o, bus.err_o});
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_cmd(input logic [2:0] f3, input logic [3:0] sel, input logic [12:0] size,
                          input logic [31:0] addr);
    bus.dma_en_i       = 1'b1;
    bus.dma_funct3_i   = f3;
    bus.dma_sel_pim_i  = sel;
    bus.dma_size_i     = size;
    bus.dma_mem_addr_i = addr;
    tick();
    bus.dma_en_i       = 1'b0;
  endtask

  task automatic wait_idle(input int max, output int cycles);
    cycles = 0;
    while (bus.dma_busy_o && cycles < max) begin
      tick();
      cycles++;
    end
  endtask

  // Drive responder inputs at the falling edge, then observe that cycle's events.
  initial begin
    bus.mem_gnt_i      = 1'b1;
    bus.pim_wr_ready_i = 1'b1;
    bus.pim_rd_valid_i = 1'b1;
    bus.mem_rd_data_i  = '0;
    bus.pim_rd_data_i  = ST_PAT;
    forever begin
      @(negedge clk_i);
      cyc++;
      bus.mem_rd_data_i  = rd_pend ? pat(rd_pend_addr) : '0;
      bus.pim_rd_data_i  = ST_PAT + 32'(st_rd_cnt);
      bus.mem_gnt_i      = gnt_toggle ? ~bus.mem_gnt_i : 1'b1;
      bus.pim_wr_ready_i = (cyc >= stall_until);
      #1;
      if (bus.mem_req_o) req_cnt++;
      if (st_occ == DEPTH) begin
        if (bus.pim_rd_ready_o) ready_full++;
        else full_blocked++;
      end
      rd_pend = bus.mem_req_o && bus.mem_gnt_i && bus.mem_read_o;
      rd_pend_addr = bus.mem_addr_o;
      if (rd_pend) begin
        rd_addr_q.push_back(bus.mem_addr_o);
        if (!bus.pim_wr_ready_i) stall_reads++;
      end
      if (bus.mem_req_o && bus.mem_gnt_i && bus.mem_write_o) begin
        wr_addr_q.push_back(bus.mem_addr_o);
        wr_data_q.push_back(bus.mem_wr_data_o);
        st_occ--;
      end
      if (bus.pim_wr_valid_o && bus.pim_wr_ready_i) begin
        pimw_data_q.push_back(bus.pim_wr_data_o);
        pimw_idx_q.push_back(int'(bus.pim_idx_o));
      end
      if (bus.pim_rd_ready_o && bus.pim_rd_valid_i) begin
        st_occ++;
        st_rd_cnt++;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int br, bp, bw, sd, rq, fb, rf, sr, ncyc, bc, g;

  initial begin
    bus.dma_en_i       = 1'b0;
    bus.dma_funct3_i   = '0;
    bus.dma_sel_pim_i  = '0;
    bus.dma_size_i     = '0;
    bus.dma_mem_addr_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check_eq("reset_outputs", outs_or(), 64'd0);
    rst_i = 1'b0;
    tick();
    check_eq("idle_outputs", outs_or(), 64'd0);

    // LOAD basic: 4 words from 0x100.
    br = rd_addr_q.size(); bp = pimw_data_q.size();
    send_cmd(3'b000, 4'b0001, 13'd16, 32'h100);
    check_eq("load_busy_rise", 64'(bus.dma_busy_o), 64'd1);
    check_eq("load_pim_sel", 64'(bus.pim_sel_o), 64'h1);
    wait_idle(50, ncyc);
    check_eq("load_busy_cycles", 64'(ncyc), 64'd7);
    check_eq("load_read_count", 64'(rd_addr_q.size() - br), 64'd4);
    check_eq("load_pim_count", 64'(pimw_data_q.size() - bp), 64'd4);
    for (int k = 0; k < 4; k++) begin
      check_eq("load_rd_addr", 64'(rd_addr_q[br+k]), 64'(32'h100 + 32'(4 * k)));
      check_eq("load_pim_data", 64'(pimw_data_q[bp+k]), 64'(pat(32'h100 + 32'(4 * k))));
      check_eq("load_pim_idx", 64'(pimw_idx_q[bp+k]), 64'(k));
    end
    check_eq("load_idx_cleared", 64'(bus.pim_idx_o), 64'd0);

    // STORE N=1 to 0x300.
    bw = wr_addr_q.size(); sd = st_rd_cnt;
    send_cmd(3'b001, 4'b0010, 13'd4, 32'h300);
    wait_idle(50, ncyc);
    check_eq("store1_busy_cycles", 64'(ncyc), 64'd3);
    check_eq("store1_wr_count", 64'(wr_addr_q.size() - bw), 64'd1);
    check_eq("store1_wr_addr", 64'(wr_addr_q[bw]), 64'h300);
    check_eq("store1_wr_data", 64'(wr_data_q[bw]), 64'(ST_PAT + 32'(sd)));

    // STORE N=8 with grant every other cycle.
    gnt_toggle = 1'b1;
    bw = wr_addr_q.size(); sd = st_rd_cnt; fb = full_blocked; rf = ready_full;
    send_cmd(3'b001, 4'b0100, 13'd32, 32'h400);
    wait_idle(100, ncyc);
    gnt_toggle = 1'b0;
    check_eq("store8_done", 64'(bus.dma_busy_o), 64'd0);
    check_eq("store8_wr_count", 64'(wr_addr_q.size() - bw), 64'd8);
    for (int k = 0; k < 8; k++) begin
      check_eq("store8_wr_addr", 64'(wr_addr_q[bw+k]), 64'(32'h400 + 32'(4 * k)));
      check_eq("store8_wr_data", 64'(wr_data_q[bw+k]), 64'(ST_PAT + 32'(sd + k)));
    end
    check_eq("store8_full_blocks_ready", 64'(full_blocked > fb), 64'd1);
    check_eq("store8_no_ready_when_full", 64'(ready_full - rf), 64'd0);

    // LOAD N=10 with the PIM stalled for 20 cycles.
    br = rd_addr_q.size(); bp = pimw_data_q.size(); sr = stall_reads;
    stall_until = cyc + 20;
    send_cmd(3'b000, 4'b1000, 13'd40, 32'h800);
    wait_idle(200, ncyc);
    check_eq("stall_done", 64'(bus.dma_busy_o), 64'd0);
    check_eq("stall_reads_le_depth", 64'((stall_reads - sr) <= int'(DEPTH)), 64'd1);
    check_eq("stall_reads_nonzero", 64'((stall_reads - sr) > 0), 64'd1);
    check_eq("stall_pim_count", 64'(pimw_data_q.size() - bp), 64'd10);
    for (int k = 0; k < 10; k++) begin
      check_eq("stall_rd_addr", 64'(rd_addr_q[br+k]), 64'(32'h800 + 32'(4 * k)));
      check_eq("stall_pim_data", 64'(pimw_data_q[bp+k]), 64'(pat(32'h800 + 32'(4 * k))));
      check_eq("stall_pim_idx", 64'(pimw_idx_q[bp+k]), 64'(k));
    end

    // Zero-length command: one busy cycle, no traffic.
    rq = req_cnt; bp = pimw_data_q.size();
    send_cmd(3'b000, 4'b0001, 13'd0, 32'h40);
    wait_idle(10, ncyc);
    check_eq("zero_busy_cycles", 64'(ncyc), 64'd1);
    check_eq("zero_no_req", 64'(req_cnt - rq), 64'd0);
    check_eq("zero_no_pim", 64'(pimw_data_q.size() - bp), 64'd0);

    // Illegal funct3: dropped.
    rq = req_cnt; bc = 0;
    send_cmd(3'b111, 4'b0001, 13'd16, 32'h40);
    for (int k = 0; k < 5; k++) begin
      bc += int'(bus.dma_busy_o);
      tick();
    end
    check_eq("illegal_no_busy", 64'(bc), 64'd0);
    check_eq("illegal_no_req", 64'(req_cnt - rq), 64'd0);

    // Reset after 2 of 8 words, then a clean LOAD.
    bp = pimw_data_q.size(); g = 0;
    send_cmd(3'b000, 4'b0001, 13'd32, 32'hA00);
    while ((pimw_data_q.size() - bp) < 2 && g < 50) begin
      tick();
      g++;
    end
    check_eq("rstmid_progress", 64'(pimw_data_q.size() - bp), 64'd2);
    rst_i = 1'b1;
    #1;
    check_eq("rstmid_outputs", outs_or(), 64'd0);
    tick();
    tick();
    rst_i = 1'b0;
    tick();
    br = rd_addr_q.size(); bp = pimw_data_q.size();
    send_cmd(3'b000, 4'b0001, 13'd4, 32'hB00);
    wait_idle(50, ncyc);
    check_eq("after_rst_busy_cycles", 64'(ncyc), 64'd4);
    check_eq("after_rst_read_count", 64'(rd_addr_q.size() - br), 64'd1);
    check_eq("after_rst_pim_data", 64'(pimw_data_q[bp]), 64'(pat(32'hB00)));
    check_eq("after_rst_pim_idx", 64'(pimw_idx_q[bp]), 64'd0);

`ifdef PIM_DMA_ALIGN_CHK_EN
    rq = req_cnt;
    send_cmd(3'b000, 4'b0001, 13'd4, 32'h102);
    check_eq("align_err_set", 64'(bus.err_o), 64'd1);
    check_eq("align_no_busy", 64'(bus.dma_busy_o), 64'd0);
    tick();
    tick();
    check_eq("align_no_req", 64'(req_cnt - rq), 64'd0);
    check_eq("align_err_sticky", 64'(bus.err_o), 64'd1);
    send_cmd(3'b000, 4'b0001, 13'd0, 32'h0);
    check_eq("align_err_cleared", 64'(bus.err_o), 64'd0);
    wait_idle(10, ncyc);
`else
    br = rd_addr_q.size(); bp = pimw_data_q.size();
    send_cmd(3'b000, 4'b0001, 13'd4, 32'h102);
    check_eq("noalign_err_zero", 64'(bus.err_o), 64'd0);
    wait_idle(50, ncyc);
    check_eq("noalign_busy_cycles", 64'(ncyc), 64'd4);
    check_eq("noalign_rd_addr", 64'(rd_addr_q[br]), 64'h100);
    check_eq("noalign_pim_data", 64'(pimw_data_q[bp]), 64'(pat(32'h100)));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
